// File: rtl/reg_scan_checker.sv
// ----------------------------------------------------------------------------
// reg_scan_checker
//
// On-chip run/check harness for the processor. A start pulse launches a run
// of a programmable number of execution cycles. During the run, every register
// write is optionally logged on the trace port. After the run, the harness
// takes over the regfile read port and sweeps every register. It compares each
// one against an expected-value ROM. It then reports pass/fail, the error count
// and the index of the first failing register.
//
// Build option:
//   REG_SCAN_TRACE_EN  defined   -> write-trace capture present
//                      undefined -> trace_* outputs tied to 0
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low
//   start        1-cycle launch pulse, honoured in IDLE or DONE only
//   num_cycles   run length sampled with start (0 selects DEF_CYCLES)
//   rwe/rd/rData monitored regfile write port
//   test_mode    1 while the harness owns the rs1 mux
//   rs_test      register index driven during the sweep
//   reg_data     regfile port A data (combinational from rs_test)
//   exp_addr     expected-ROM address, mirrors rs_test
//   exp_data     expected-ROM data, one-cycle latency
//   trace_*      one-cycle record of each logged write
//   busy/done    status: RUN or SCAN / DONE
//   pass         done with zero mismatches
//   err_count    saturating mismatch count
//   first_fail   first mismatching index, all-ones when none
// ----------------------------------------------------------------------------
module reg_scan_checker #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int CYC_W      = 10,
  parameter int DEF_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  input  logic              rwe,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] rData,
  output logic              test_mode,
  output logic [ADDR_W-1:0] rs_test,
  input  logic [DATA_W-1:0] reg_data,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              trace_valid,
  output logic [CYC_W-1:0]  trace_cycle,
  output logic [ADDR_W-1:0] trace_rd,
  output logic [DATA_W-1:0] trace_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CYC_W-1:0]  DEF_N     = CYC_W'(DEF_CYCLES);
  localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);
  localparam logic [ADDR_W:0]   SCAN_LAST = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0]   ERR_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] FF_NONE   = {ADDR_W{1'b1}};

  state_t            state_r;
  state_t            state_nxt_s;
  logic              start_ok_s;
  logic              mismatch_s;
  logic [CYC_W-1:0]  n_r;
  logic [CYC_W-1:0]  cnt_r;
  logic [ADDR_W:0]   scnt_r;
  logic              cmp_valid_r;
  logic [ADDR_W-1:0] cmp_idx_r;
  logic [DATA_W-1:0] reg_q_r;
  logic              test_mode_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W:0]   err_count_r;
  logic [ADDR_W-1:0] first_fail_r;

  // A start pulse is only honoured when no run or sweep is in flight.
  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign mismatch_s = (reg_q_r != exp_data);

  // Next-state decode for the run/scan sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_r == (n_r - CYC_ONE)) state_nxt_s = ST_SCAN;
        else                          state_nxt_s = ST_RUN;
      end
      ST_SCAN: begin
        // The final cycle only retires the compare of the last index.
        if (scnt_r == SCAN_LAST) state_nxt_s = ST_DONE;
        else                     state_nxt_s = ST_SCAN;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      test_mode_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      test_mode_r <= (state_nxt_s == ST_SCAN);
      busy_r      <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_SCAN);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  // Run length capture and run-cycle counter (cnt is 0 in the first RUN cycle).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_r   <= {CYC_W{1'b0}};
      cnt_r <= {CYC_W{1'b0}};
    end else if (start_ok_s) begin
      n_r   <= (num_cycles == {CYC_W{1'b0}}) ? DEF_N : num_cycles;
      cnt_r <= {CYC_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      cnt_r <= cnt_r + CYC_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sweep counter: 0 on SCAN entry, and back to 0 in DONE so rs_test parks at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scnt_r <= {(ADDR_W+1){1'b0}};
    end else if ((state_r == ST_SCAN) && (state_nxt_s == ST_SCAN)) begin
      scnt_r <= scnt_r + ERR_ONE;
    end else begin
      scnt_r <= {(ADDR_W+1){1'b0}};
    end
  end

  // Register reg_data one cycle so it lines up with the ROM's read latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmp_valid_r <= 1'b0;
      cmp_idx_r   <= {ADDR_W{1'b0}};
      reg_q_r     <= {DATA_W{1'b0}};
    end else if (state_r == ST_SCAN) begin
      cmp_valid_r <= (scnt_r < SCAN_LAST);
      cmp_idx_r   <= scnt_r[ADDR_W-1:0];
      reg_q_r     <= reg_data;
    end else begin
      cmp_valid_r <= 1'b0;
      cmp_idx_r   <= cmp_idx_r;
      reg_q_r     <= reg_q_r;
    end
  end

  // Error accounting: a saturating count, plus the first failing index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count_r  <= {(ADDR_W+1){1'b0}};
      first_fail_r <= FF_NONE;
    end else if (start_ok_s) begin
      err_count_r  <= {(ADDR_W+1){1'b0}};
      first_fail_r <= FF_NONE;
    end else if (cmp_valid_r && mismatch_s) begin
      if (err_count_r != SCAN_LAST) err_count_r <= err_count_r + ERR_ONE;
      else                          err_count_r <= err_count_r;
      // Only the first mismatch is latched.
      if (first_fail_r == FF_NONE) first_fail_r <= cmp_idx_r;
      else                         first_fail_r <= first_fail_r;
    end else begin
      err_count_r  <= err_count_r;
      first_fail_r <= first_fail_r;
    end
  end

`ifdef REG_SCAN_TRACE_EN
  logic              trace_valid_r;
  logic [CYC_W-1:0]  trace_cycle_r;
  logic [ADDR_W-1:0] trace_rd_r;
  logic [DATA_W-1:0] trace_data_r;

  // Log RUN-phase writes to non-zero registers, one cycle after they occur.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trace_valid_r <= 1'b0;
      trace_cycle_r <= {CYC_W{1'b0}};
      trace_rd_r    <= {ADDR_W{1'b0}};
      trace_data_r  <= {DATA_W{1'b0}};
    end else if ((state_r == ST_RUN) && rwe && (rd != {ADDR_W{1'b0}})) begin
      trace_valid_r <= 1'b1;
      trace_cycle_r <= cnt_r;
      trace_rd_r    <= rd;
      trace_data_r  <= rData;
    end else begin
      trace_valid_r <= 1'b0;
      trace_cycle_r <= trace_cycle_r;
      trace_rd_r    <= trace_rd_r;
      trace_data_r  <= trace_data_r;
    end
  end

  assign trace_valid = trace_valid_r;
  assign trace_cycle = trace_cycle_r;
  assign trace_rd    = trace_rd_r;
  assign trace_data  = trace_data_r;
`else
  logic unused_trace_s;

  assign unused_trace_s = ^{rwe, rd, rData};
  assign trace_valid    = 1'b0;
  assign trace_cycle    = {CYC_W{1'b0}};
  assign trace_rd       = {ADDR_W{1'b0}};
  assign trace_data     = {DATA_W{1'b0}};
`endif

  assign test_mode  = test_mode_r;
  assign rs_test    = scnt_r[ADDR_W-1:0];
  assign exp_addr   = scnt_r[ADDR_W-1:0];
  assign busy       = busy_r;
  assign done       = done_r;
  assign err_count  = err_count_r;
  assign first_fail = first_fail_r;
  assign pass       = done_r && (err_count_r == {(ADDR_W+1){1'b0}});

endmodule

// File: tb/tb_reg_scan_checker.sv
module tb_reg_scan_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  num_cycles = 10'd0;
  logic        rwe = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] rData = 32'd0;
  logic        test_mode;
  logic [4:0]  rs_test;
  logic [31:0] reg_data;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data = 32'd0;
  logic        trace_valid;
  logic [9:0]  trace_cycle;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  err_count;
  logic [4:0]  first_fail;

  logic [31:0] regs [32];
  logic [31:0] rom  [32];

  int checks = 0;
  int failures = 0;

  int          busy_cnt, run_cnt, trace_cnt;
  logic [9:0]  tc;
  logic [4:0]  trd;
  logic [31:0] tdat;

`ifdef REG_SCAN_TRACE_EN
  localparam int EXP_TRACES = 1;
`else
  localparam int EXP_TRACES = 0;
`endif

  reg_scan_checker dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .rwe(rwe), .rd(rd), .rData(rData), .test_mode(test_mode),
    .rs_test(rs_test), .reg_data(reg_data), .exp_addr(exp_addr),
    .exp_data(exp_data), .trace_valid(trace_valid), .trace_cycle(trace_cycle),
    .trace_rd(trace_rd), .trace_data(trace_data), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_fail(first_fail)
  );

  always #5 clock = ~clock;

  // Regfile read port A model and synchronous expected ROM.
  assign reg_data = regs[rs_test];
  always @(posedge clock) exp_data <= rom[exp_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Launch one run, inject an optional write in run cycle wr_cyc, and measure.
  task automatic do_run(input logic [9:0] ncyc, input int wr_cyc, input logic [4:0] wr_rd,
                        input logic [31:0] wr_data, input bit start_in_scan);
    int k;
    bit sent;
    k = 0; sent = 1'b0;
    busy_cnt = 0; run_cnt = 0; trace_cnt = 0;
    tc = 10'd0; trd = 5'd0; tdat = 32'd0;
    @(negedge clock); start = 1'b1; num_cycles = ncyc;
    @(negedge clock); start = 1'b0;
    while (busy && k < 2000) begin
      busy_cnt++;
      if (!test_mode) run_cnt++;
      if (trace_valid) begin
        trace_cnt++; tc = trace_cycle; trd = trace_rd; tdat = trace_data;
      end
      if (k == wr_cyc) begin rwe = 1'b1; rd = wr_rd; rData = wr_data; end
      else begin rwe = 1'b0; rd = 5'd0; rData = 32'd0; end
      if (start_in_scan && test_mode && !sent) begin start = 1'b1; sent = 1'b1; end
      else start = 1'b0;
      @(negedge clock);
      k++;
    end
    rwe = 1'b0; start = 1'b0;
    check_val("run_bounded", 32'(k < 2000), 32'd1);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 32; i++) begin
      regs[i] = (i == 0) ? 32'd0 : 32'h100 + 32'(i * 7);
      rom[i]  = regs[i];
    end

    // Reset state.
    repeat (3) @(negedge clock);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_test_mode", 32'(test_mode), 32'd0);
    check_val("rst_pass", 32'(pass), 32'd0);
    check_val("rst_err", 32'(err_count), 32'd0);
    check_val("rst_ff", 32'(first_fail), 32'd31);
    check_val("rst_rs_test", 32'(rs_test), 32'd0);
    reset = 1'b1;

    // Writes while idle are not logged.
    rwe = 1'b1; rd = 5'd3; rData = 32'd5;
    @(negedge clock); @(negedge clock);
    check_val("idle_no_trace", 32'(trace_valid), 32'd0);
    rwe = 1'b0;

    // Test 1 + 3: 4-cycle run, one logged write, matching ROM.
    do_run(10'd4, 2, 5'd3, 32'd7, 1'b0);
    check_val("t1_busy_cycles", 32'(busy_cnt), 32'd37);
    check_val("t1_run_cycles", 32'(run_cnt), 32'd4);
    check_val("t1_trace_cnt", 32'(trace_cnt), 32'(EXP_TRACES));
    if (EXP_TRACES == 1) begin
      check_val("t1_trace_cycle", 32'(tc), 32'd2);
      check_val("t1_trace_rd", 32'(trd), 32'd3);
      check_val("t1_trace_data", tdat, 32'd7);
    end
    check_val("t1_done", 32'(done), 32'd1);
    check_val("t3_pass", 32'(pass), 32'd1);
    check_val("t3_err", 32'(err_count), 32'd0);
    check_val("t3_ff", 32'(first_fail), 32'd31);
    check_val("t1_test_mode_off", 32'(test_mode), 32'd0);
    check_val("t1_rs_test_parked", 32'(rs_test), 32'd0);

    // Test 2: num_cycles=0 selects 255 run cycles.
    do_run(10'd0, -1, 5'd0, 32'd0, 1'b0);
    check_val("t2_run_cycles", 32'(run_cnt), 32'd255);
    check_val("t2_busy_cycles", 32'(busy_cnt), 32'd288);

    // Test 4: regs 5 and 9 disagree with the ROM.
    regs[5] = 32'd42; rom[5] = 32'd41;
    regs[9] = 32'd42; rom[9] = 32'd41;
    do_run(10'd3, -1, 5'd0, 32'd0, 1'b0);
    check_val("t4_err", 32'(err_count), 32'd2);
    check_val("t4_ff", 32'(first_fail), 32'd5);
    check_val("t4_pass", 32'(pass), 32'd0);
    check_val("t4_done", 32'(done), 32'd1);

    // Test 5: r0 write is not logged; start during SCAN is ignored.
    do_run(10'd5, 1, 5'd0, 32'd99, 1'b1);
    check_val("t5_trace_cnt", 32'(trace_cnt), 32'd0);
    check_val("t5_busy_cycles", 32'(busy_cnt), 32'd38);
    check_val("t5_err", 32'(err_count), 32'd2);
    check_val("t5_done", 32'(done), 32'd1);

    // Boundary: mismatches at r0 and r31 only.
    regs[5] = rom[5]; regs[9] = rom[9];
    rom[0] = 32'd1; rom[31] = 32'hdead_beef;
    do_run(10'd1, -1, 5'd0, 32'd0, 1'b0);
    check_val("edge_err", 32'(err_count), 32'd2);
    check_val("edge_ff", 32'(first_fail), 32'd0);
    rom[0] = 32'd0; rom[31] = regs[31];

    // Test 6: reset mid-SCAN aborts; a fresh start then runs cleanly.
    regs[5] = 32'd42; regs[9] = 32'd42;
    @(negedge clock); start = 1'b1; num_cycles = 10'd2;
    @(negedge clock); start = 1'b0;
    k = 0;
    while (!test_mode && k < 100) begin @(negedge clock); k++; end
    check_val("t6_scan_reached", 32'(test_mode), 32'd1);
    repeat (20) @(negedge clock);
    check_val("t6_err_mid", 32'(err_count), 32'd2);
    reset = 1'b0;
    #1;
    check_val("t6_test_mode", 32'(test_mode), 32'd0);
    check_val("t6_err", 32'(err_count), 32'd0);
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_ff", 32'(first_fail), 32'd31);
    @(negedge clock); reset = 1'b1;
    regs[5] = rom[5]; regs[9] = rom[9];
    do_run(10'd4, 2, 5'd3, 32'd7, 1'b0);
    check_val("t6_busy_cycles", 32'(busy_cnt), 32'd37);
    check_val("t6_trace_cnt", 32'(trace_cnt), 32'(EXP_TRACES));
    check_val("t6_pass", 32'(pass), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
